// File: rtl/tdc_pkg.sv
// Shared types for the TDC event readout path.
// Event record layout and capture FSM states.
package tdc_pkg;

  localparam int TDC_DATA_W = 32;

  typedef struct packed {
    logic [TDC_DATA_W-1:0] pulseWidth;
    logic [TDC_DATA_W-1:0] timestamp;
  } tdc_event_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } readout_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry visible on data_o
// whenever valid_o is high; storage, pointers and occupancy.
module sync_fifo_fwft #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  // Gate with valid so a drained FIFO presents zeros, not stale data.
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  // Storage array: contents only matter where count says they are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally; occupancy moves only on push-xor-pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/tdc_event_readout.sv
// Capture side for one TDC channel: latch events, re-arm the TDC,
// queue into a FWFT FIFO and keep overflow/drop statistics.
module tdc_event_readout
  import tdc_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         DATA_W     = TDC_DATA_W,
  parameter logic [7:0] CHANNEL_ID = 8'd0,
  parameter int         DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  output logic                  o_tdc_enable,
  input  logic                  i_tdc_hasEvent,
  input  logic [DATA_W-1:0]     i_tdc_timestamp,
  input  logic [DATA_W-1:0]     i_tdc_pulseWidth,
  output logic                  o_tdc_clear,
  output logic                  o_evt_valid,
  input  logic                  i_evt_ready,
  output logic [2*DATA_W-1:0]   o_evt_data,
  output logic [7:0]            o_evt_channel,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                  o_overflow,
  output logic [DROP_W-1:0]     o_drop_count,
  input  logic                  i_status_clear
);

  readout_state_t    state_q;
  logic              clear_q;
  logic              en_q;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  tdc_event_t        evt;
  logic              capture;
  logic              pop;
  logic              full;
  logic              drop;

  assign evt.pulseWidth = i_tdc_pulseWidth;
  assign evt.timestamp  = i_tdc_timestamp;

  assign capture = (state_q == IDLE) && i_tdc_hasEvent;
  assign pop     = o_evt_valid && i_evt_ready;
  assign drop    = capture && full && !pop;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .data_i  (evt),
    .pop_i   (i_evt_ready),
    .data_o  (o_evt_data),
    .valid_o (o_evt_valid),
    .full_o  (full),
    .count_o (o_fifo_count)
  );

  // Capture FSM; the clear pulse is registered alongside entry to CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_tdc_hasEvent) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
          end
        end
        CLEAR:    state_q <= WAIT_LOW;
        WAIT_LOW: if (!i_tdc_hasEvent) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Status next-state: clear first, so a coincident drop still lands.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (i_status_clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != '1) drop_d = drop_d + 1'b1;
    end
  end

  // Status and channel-enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
      en_q   <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      en_q   <= i_enable;
    end
  end

  assign o_tdc_clear   = clear_q;
  assign o_tdc_enable  = en_q;
  assign o_overflow    = ovf_q;
  assign o_drop_count  = drop_q;
  assign o_evt_channel = CHANNEL_ID;

endmodule

// File: tb/tb_tdc_event_readout.sv
// Directed bench for tdc_event_readout: vector table for the
// basic capture/pop flow, hand sequences for full/drop/reset cases.
module tb_tdc_event_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        ten;
  logic        he;
  logic [31:0] ts;
  logic [31:0] tot;
  logic        clr;
  logic        vld;
  logic        rdy;
  logic [63:0] dat;
  logic [7:0]  chn;
  logic [4:0]  cnt;
  logic        ovf;
  logic [15:0] drp;
  logic        sc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tdc_event_readout dut (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (en),
    .o_tdc_enable     (ten),
    .i_tdc_hasEvent   (he),
    .i_tdc_timestamp  (ts),
    .i_tdc_pulseWidth (tot),
    .o_tdc_clear      (clr),
    .o_evt_valid      (vld),
    .i_evt_ready      (rdy),
    .o_evt_data       (dat),
    .o_evt_channel    (chn),
    .o_fifo_count     (cnt),
    .o_overflow       (ovf),
    .o_drop_count     (drp),
    .i_status_clear   (sc)
  );

  typedef struct {
    logic        en;
    logic        he;
    logic [31:0] ts;
    logic [31:0] tot;
    logic        rdy;
    logic        v;
    logic [63:0] d;
    logic [4:0]  c;
    logic        clr;
    logic        ten;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic e, input logic h,
    input logic [31:0] t, input logic [31:0] w,
    input logic r, input logic v,
    input logic [63:0] d, input logic [4:0] c,
    input logic cl, input logic te);
    vec_t x;
    x.en = e; x.he = h; x.ts = t; x.tot = w; x.rdy = r;
    x.v = v; x.d = d; x.c = c; x.clr = cl; x.ten = te;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One TDC event; ready/status_clear only on the capture edge.
  task automatic pulse_event(input logic [31:0] t,
                             input logic [31:0] w,
                             input logic r,
                             input logic s,
                             output logic cl);
    he = 1'b1; ts = t; tot = w; rdy = r; sc = s;
    tick();
    cl = clr;
    he = 1'b0; rdy = 1'b0; sc = 1'b0;
    tick();
    tick();
  endtask

  logic        c_seen;
  logic [63:0] exp_d;

  initial begin
    reset = 1'b1; en = 1'b1; he = 1'b1;
    ts = 32'h0; tot = 32'h0; rdy = 1'b0; sc = 1'b0;

    tbl[0]  = mk(1,0,32'h0,  32'h0, 0, 0,64'h0,                   0,0,1);
    tbl[1]  = mk(1,1,32'h100,32'h20,0, 1,64'h00000020_00000100,   1,1,1);
    tbl[2]  = mk(1,0,32'h0,  32'h0, 0, 1,64'h00000020_00000100,   1,0,1);
    tbl[3]  = mk(1,0,32'h0,  32'h0, 0, 1,64'h00000020_00000100,   1,0,1);
    tbl[4]  = mk(1,0,32'h0,  32'h0, 1, 0,64'h0,                   0,0,1);
    tbl[5]  = mk(1,1,32'h200,32'h5, 1, 1,64'h00000005_00000200,   1,1,1);
    tbl[6]  = mk(1,0,32'h0,  32'h0, 0, 1,64'h00000005_00000200,   1,0,1);
    tbl[7]  = mk(1,0,32'h0,  32'h0, 1, 0,64'h0,                   0,0,1);
    tbl[8]  = mk(1,1,32'h300,32'h7, 0, 1,64'h00000007_00000300,   1,1,1);
    tbl[9]  = mk(1,1,32'h999,32'h9, 0, 1,64'h00000007_00000300,   1,0,1);
    tbl[10] = mk(1,1,32'h999,32'h9, 0, 1,64'h00000007_00000300,   1,0,1);
    tbl[11] = mk(1,0,32'h0,  32'h0, 0, 1,64'h00000007_00000300,   1,0,1);
    tbl[12] = mk(1,1,32'h400,32'h9, 1, 1,64'h00000009_00000400,   1,1,1);
    tbl[13] = mk(1,0,32'h0,  32'h0, 0, 1,64'h00000009_00000400,   1,0,1);
    tbl[14] = mk(0,0,32'h0,  32'h0, 0, 1,64'h00000009_00000400,   1,0,0);
    tbl[15] = mk(1,0,32'h0,  32'h0, 1, 0,64'h0,                   0,0,1);

    // reset held with a pending event: everything quiet
    tick(); tick();
    chk("rst.ten", 64'(ten), 64'h0);
    chk("rst.clr", 64'(clr), 64'h0);
    chk("rst.vld", 64'(vld), 64'h0);
    chk("rst.cnt", 64'(cnt), 64'h0);
    chk("rst.dat", dat, 64'h0);
    chk("rst.ovf", 64'(ovf), 64'h0);
    chk("rst.drp", 64'(drp), 64'h0);
    chk("rst.chn", 64'(chn), 64'h0);
    reset = 1'b0; he = 1'b0;

    // basic capture / pop flow
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; he = tbl[i].he; ts = tbl[i].ts;
      tot = tbl[i].tot; rdy = tbl[i].rdy;
      tick();
      chk($sformatf("row%0d.ten", i), 64'(ten), 64'(tbl[i].ten));
      chk($sformatf("row%0d.vld", i), 64'(vld), 64'(tbl[i].v));
      chk($sformatf("row%0d.dat", i), dat, tbl[i].d);
      chk($sformatf("row%0d.cnt", i), 64'(cnt), 64'(tbl[i].c));
      chk($sformatf("row%0d.clr", i), 64'(clr), 64'(tbl[i].clr));
      chk($sformatf("row%0d.ovf", i), 64'(ovf), 64'h0);
    end
    he = 1'b0; rdy = 1'b0; en = 1'b1;
    tick();

    // backpressure: fill to 16
    for (int i = 0; i < 16; i++) begin
      pulse_event(32'h1000 + 32'(i), 32'(i), 1'b0, 1'b0, c_seen);
      chk($sformatf("fill%0d.clr", i), 64'(c_seen), 64'h1);
    end
    chk("full.cnt", 64'(cnt), 64'd16);
    chk("full.dat", dat, 64'h00000000_00001000);
    chk("full.ovf", 64'(ovf), 64'h0);

    // 17th event is dropped, TDC still cleared
    pulse_event(32'hDEAD, 32'hBEEF, 1'b0, 1'b0, c_seen);
    chk("drop.clr", 64'(c_seen), 64'h1);
    chk("drop.cnt", 64'(cnt), 64'd16);
    chk("drop.ovf", 64'(ovf), 64'h1);
    chk("drop.drp", 64'(drp), 64'd1);

    // full FIFO with a pop on the capture edge accepts the push
    pulse_event(32'hAAA, 32'hBBB, 1'b1, 1'b0, c_seen);
    chk("fpop.clr", 64'(c_seen), 64'h1);
    chk("fpop.cnt", 64'(cnt), 64'd16);
    chk("fpop.drp", 64'(drp), 64'd1);
    chk("fpop.dat", dat, 64'h00000001_00001001);

    // drain in order, ending with the accepted event
    for (int k = 0; k < 16; k++) begin
      if (k < 15) exp_d = {32'(k + 1), 32'h1000 + 32'(k + 1)};
      else        exp_d = 64'h00000BBB_00000AAA;
      chk($sformatf("drain%0d.dat", k), dat, exp_d);
      rdy = 1'b1;
      tick();
    end
    rdy = 1'b0;
    chk("drain.cnt", 64'(cnt), 64'd0);
    chk("drain.vld", 64'(vld), 64'h0);

    // status clear alone
    sc = 1'b1;
    tick();
    sc = 1'b0;
    chk("sclr.ovf", 64'(ovf), 64'h0);
    chk("sclr.drp", 64'(drp), 64'h0);

    // refill, two drops, then clear coincident with a third drop
    for (int i = 0; i < 16; i++)
      pulse_event(32'h2000 + 32'(i), 32'h0, 1'b0, 1'b0, c_seen);
    pulse_event(32'h1, 32'h1, 1'b0, 1'b0, c_seen);
    pulse_event(32'h2, 32'h2, 1'b0, 1'b0, c_seen);
    chk("drop2.drp", 64'(drp), 64'd2);
    chk("drop2.ovf", 64'(ovf), 64'h1);
    pulse_event(32'h3, 32'h3, 1'b0, 1'b1, c_seen);
    chk("scdrop.clr", 64'(c_seen), 64'h1);
    chk("scdrop.ovf", 64'(ovf), 64'h1);
    chk("scdrop.drp", 64'(drp), 64'd1);
    chk("scdrop.cnt", 64'(cnt), 64'd16);
    rdy = 1'b1;
    repeat (16) tick();
    rdy = 1'b0;
    chk("empty.cnt", 64'(cnt), 64'd0);

    // hasEvent held high: one entry only until it falls
    he = 1'b1; ts = 32'h555; tot = 32'h66;
    tick();
    chk("hold.cnt0", 64'(cnt), 64'd1);
    chk("hold.clr0", 64'(clr), 64'h1);
    ts = 32'h777;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d.cnt", i), 64'(cnt), 64'd1);
      chk($sformatf("hold%0d.clr", i), 64'(clr), 64'h0);
    end
    chk("hold.dat", dat, 64'h00000066_00000555);
    he = 1'b0;
    tick();
    chk("fall.cnt", 64'(cnt), 64'd1);
    he = 1'b1;
    tick();
    chk("rearm.cnt", 64'(cnt), 64'd2);
    chk("rearm.clr", 64'(clr), 64'h1);
    he = 1'b0;
    tick(); tick();

    // reset during CLEAR cuts the pulse and empties the FIFO at once
    he = 1'b1; ts = 32'h888; tot = 32'h11;
    tick();
    chk("pre.clr", 64'(clr), 64'h1);
    chk("pre.cnt", 64'(cnt), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.clr", 64'(clr), 64'h0);
    chk("mid.cnt", 64'(cnt), 64'd0);
    chk("mid.vld", 64'(vld), 64'h0);
    chk("mid.ten", 64'(ten), 64'h0);
    chk("mid.ovf", 64'(ovf), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post.cnt", 64'(cnt), 64'd1);
    chk("post.clr", 64'(clr), 64'h1);
    chk("post.dat", dat, 64'h00000011_00000888);
    chk("post.ten", 64'(ten), 64'h1);
    he = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
